// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60Hz VGA raster timing generator. Divides the system
//            clock down to the pixel rate, runs the horizontal/vertical
//            raster counters and produces registered hSync/vSync/bright
//            plus per-pixel and per-frame strobes.
//            Optional build macro FRAME_COUNT_EN adds an 8-bit frame counter
//            output (frame_count) for downstream animation timing.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,    // system clocks per pixel, >= 1
    parameter int H_SYNC    = 96,   // hSync low width in pixels
    parameter int H_BP_END  = 144,  // first active pixel column
    parameter int H_ACT_END = 784,  // first column after active region
    parameter int H_TOTAL   = 800,  // pixels per line, <= 1024
    parameter int V_SYNC    = 2,    // vSync low width in lines
    parameter int V_BP_END  = 35,   // first active line
    parameter int V_ACT_END = 515,  // first line after active region
    parameter int V_TOTAL   = 525   // lines per frame, <= 1024
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_en,
    output logic       frame_tick
`ifdef FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    // A divide-by-one still needs a one-bit divider register so the
    // wrap compare stays well formed; it simply sits at zero.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] C_DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       C_H_MAX     = 10'(H_TOTAL - 1);
    localparam logic [9:0]       C_V_MAX     = 10'(V_TOTAL - 1);
    localparam logic [9:0]       C_H_SYNC    = 10'(H_SYNC);
    localparam logic [9:0]       C_H_BP_END  = 10'(H_BP_END);
    localparam logic [9:0]       C_H_ACT_END = 10'(H_ACT_END);
    localparam logic [9:0]       C_V_SYNC    = 10'(V_SYNC);
    localparam logic [9:0]       C_V_BP_END  = 10'(V_BP_END);
    localparam logic [9:0]       C_V_ACT_END = 10'(V_ACT_END);

    logic [DIV_W-1:0] r_div;

    logic       w_adv;          // pixel advance on this edge
    logic       w_h_wrap;       // current column is the last of the line
    logic       w_v_wrap;       // current line is the last of the frame
    logic       w_frame_wrap;   // this edge moves the raster back to (0,0)
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_hsync_next;
    logic       w_vsync_next;
    logic       w_h_active;
    logic       w_v_active;
    logic       w_bright_next;

    assign w_adv        = (r_div == C_DIV_MAX);
    assign w_h_wrap     = (hCount == C_H_MAX);
    assign w_v_wrap     = (vCount == C_V_MAX);
    assign w_frame_wrap = w_adv && w_h_wrap && w_v_wrap;

    // Next raster position: counters only move on a divider wrap, and the
    // line counter only moves when the column counter wraps.
    always_comb begin
        w_h_next = hCount;
        w_v_next = vCount;
        if (w_adv) begin
            if (w_h_wrap) begin
                w_h_next = 10'd0;
                w_v_next = w_v_wrap ? 10'd0 : (vCount + 10'd1);
            end else begin
                w_h_next = hCount + 10'd1;
            end
        end
    end

    // Decodes are taken from the next position so that the registered
    // sync/window outputs change on the same edge as the counters.
    assign w_hsync_next  = (w_h_next >= C_H_SYNC);
    assign w_vsync_next  = (w_v_next >= C_V_SYNC);
    assign w_h_active    = (w_h_next >= C_H_BP_END) && (w_h_next < C_H_ACT_END);
    assign w_v_active    = (w_v_next >= C_V_BP_END) && (w_v_next < C_V_ACT_END);
    assign w_bright_next = w_h_active && w_v_active;

    // Pixel-rate divider and its registered advance strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            pix_en <= 1'b0;
        end else begin
            r_div  <= w_adv ? '0 : (r_div + 1'b1);
            pix_en <= w_adv;
        end
    end

    // Raster position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCount <= 10'd0;
            vCount <= 10'd0;
        end else begin
            hCount <= w_h_next;
            vCount <= w_v_next;
        end
    end

    // Registered sync, display-window and frame strobe outputs. Position
    // (0,0) lies inside both sync pulses, hence the low reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            hSync      <= w_hsync_next;
            vSync      <= w_vsync_next;
            bright     <= w_bright_next;
            frame_tick <= w_frame_wrap;
        end
    end

`ifdef FRAME_COUNT_EN
    // Free-running frame counter, stepping on the same edge as frame_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= 8'd0;
        end else if (w_frame_wrap) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench for vga_timing_gen. A reduced-raster
//            instance is checked against a queued expected sequence, a
//            full-size instance is spot-checked on line timing, and a tiny
//            divide-by-one instance covers the every-cycle strobe and the
//            optional frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    // Reduced raster for the scoreboarded instance: 50 x 20, 1000 pixels.
    localparam int S_HS  = 6;
    localparam int S_HBP = 9;
    localparam int S_HAE = 45;
    localparam int S_HT  = 50;
    localparam int S_VS  = 2;
    localparam int S_VBP = 5;
    localparam int S_VAE = 17;
    localparam int S_VT  = 20;

`ifdef FRAME_COUNT_EN
    localparam int N_RUN2 = 4104;
`else
    localparam int N_RUN2 = 240;
`endif

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [9:0] s_h, s_v, d_h, d_v, t_h, t_v;
    logic s_hs, s_vs, s_br, s_pe, s_ft;
    logic d_hs, d_vs, d_br, d_pe, d_ft;
    logic t_hs, t_vs, t_br, t_pe, t_ft;
`ifdef FRAME_COUNT_EN
    logic [7:0] s_fc, d_fc, t_fc;
`endif

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(4), .H_SYNC(S_HS), .H_BP_END(S_HBP), .H_ACT_END(S_HAE), .H_TOTAL(S_HT),
        .V_SYNC(S_VS), .V_BP_END(S_VBP), .V_ACT_END(S_VAE), .V_TOTAL(S_VT)
    ) u_dut (
        .clk(clk), .rst(rst), .hCount(s_h), .vCount(s_v), .hSync(s_hs), .vSync(s_vs),
        .bright(s_br), .pix_en(s_pe), .frame_tick(s_ft)
`ifdef FRAME_COUNT_EN
        , .frame_count(s_fc)
`endif
    );

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .hCount(d_h), .vCount(d_v), .hSync(d_hs), .vSync(d_vs),
        .bright(d_br), .pix_en(d_pe), .frame_tick(d_ft)
`ifdef FRAME_COUNT_EN
        , .frame_count(d_fc)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(1), .H_BP_END(2), .H_ACT_END(3), .H_TOTAL(4),
        .V_SYNC(1), .V_BP_END(2), .V_ACT_END(3), .V_TOTAL(4)
    ) u_tiny (
        .clk(clk), .rst(rst), .hCount(t_h), .vCount(t_v), .hSync(t_hs), .vSync(t_vs),
        .bright(t_br), .pix_en(t_pe), .frame_tick(t_ft)
`ifdef FRAME_COUNT_EN
        , .frame_count(t_fc)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected raster state after the k-th pixel advance since reset release.
    function automatic exp_t model(input int k);
        exp_t e;
        int p, h, v;
        p = k % (S_HT * S_VT);
        h = p % S_HT;
        v = p / S_HT;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h >= S_HS);
        e.vs = (v >= S_VS);
        e.br = (h >= S_HBP) && (h < S_HAE) && (v >= S_VBP) && (v < S_VAE);
        e.ft = (p == 0);
        return e;
    endfunction

    task automatic push_exp(input int n);
        for (int k = 1; k <= n; k++) sb_q.push_back(model(k));
    endtask

    // Monitor: every pixel advance of the reduced instance consumes one
    // queued expectation; frame_tick must stay low between advances.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (s_pe) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: advance at (%0d,%0d) with no expectation queued", s_h, s_v);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_raster", {8'd0, s_h, s_v, s_hs, s_vs, s_br, s_ft}, {8'd0, e});
                end
            end else begin
                check("sb_idle_frame_tick", {31'd0, s_ft}, 32'd0);
            end
        end
    end

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  adv;
        int  ft_seen;
        int  t_ticks;
        bit  found;

        repeat (3) @(negedge clk);
        check("rst_dut_outputs",  {17'd0, s_h, s_v, s_hs, s_vs, s_br, s_pe, s_ft}, 32'd0);
        check("rst_def_outputs",  {17'd0, d_h, d_v, d_hs, d_vs, d_br, d_pe, d_ft}, 32'd0);
        check("rst_tiny_outputs", {17'd0, t_h, t_v, t_hs, t_vs, t_br, t_pe, t_ft}, 32'd0);
`ifdef FRAME_COUNT_EN
        check("rst_frame_count", {24'd0, s_fc}, 32'd0);
`endif

        // Phase 1: fresh start, two full reduced frames.
        @(negedge clk);
        push_exp(3000);
        rst = 1'b0;
        adv = 0;
        ft_seen = 0;
        for (int cyc = 1; cyc <= 8010; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc <= 8)   check("def_pix_en_phase", {31'd0, d_pe}, {31'd0, (cyc % 4) == 0});
            if (cyc == 4)   check("def_first_adv", {22'd0, d_h, d_v}, {22'd0, 10'd1, 10'd0});
            if (cyc == 383) check("def_hsync_383", {31'd0, d_hs}, 32'd0);
            if (cyc == 384) check("def_hsync_384", {21'd0, d_h, d_hs}, {21'd0, 10'd96, 1'b1});
            if (cyc == 3199) check("def_line_end", {20'd0, d_h, d_v, d_hs, d_vs}, {20'd0, 10'd799, 10'd0, 2'b10});
            if (cyc == 3200) check("def_line_wrap", {20'd0, d_h, d_v, d_hs, d_vs}, {20'd0, 10'd0, 10'd1, 2'b00});
            if (cyc <= 20)  check("tiny_pix_en", {31'd0, t_pe}, 32'd1);
            if (s_ft) begin
                ft_seen++;
                check("dut_frame_tick_cycle", cyc, ft_seen * 4000);
            end
            if (s_pe) begin
                adv++;
                case (adv)
                    5:    check("dir_k5",    {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd5,  10'd0,  3'b000});
                    6:    check("dir_k6",    {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd6,  10'd0,  3'b100});
                    50:   check("dir_k50",   {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd0,  10'd1,  3'b000});
                    100:  check("dir_k100",  {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd0,  10'd2,  3'b010});
                    209:  check("dir_k209",  {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd9,  10'd4,  3'b110});
                    258:  check("dir_k258",  {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd8,  10'd5,  3'b110});
                    259:  check("dir_k259",  {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd9,  10'd5,  3'b111});
                    294:  check("dir_k294",  {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd44, 10'd5,  3'b111});
                    295:  check("dir_k295",  {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd45, 10'd5,  3'b110});
                    809:  check("dir_k809",  {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd9,  10'd16, 3'b111});
                    859:  check("dir_k859",  {9'd0, s_h, s_v, s_hs, s_vs, s_br}, {9'd0, 10'd9,  10'd17, 3'b110});
                    999:  check("dir_k999",  {8'd0, s_h, s_v, s_hs, s_vs, s_br, s_ft}, {8'd0, 10'd49, 10'd19, 4'b1100});
                    1000: check("dir_k1000", {8'd0, s_h, s_v, s_hs, s_vs, s_br, s_ft}, {8'd0, 10'd0,  10'd0,  4'b0001});
                    default: ;
                endcase
            end
        end
        check("dut_frame_tick_count", ft_seen, 2);

        // Phase 2: asynchronous reset in the middle of a pixel period.
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (s_h == 10'd20 && s_v == 10'd10) found = 1'b1;
        end
        check("reach_mid_frame", {31'd0, found}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_dut", {17'd0, s_h, s_v, s_hs, s_vs, s_br, s_pe, s_ft}, 32'd0);
        check("async_rst_def", {17'd0, d_h, d_v, d_hs, d_vs, d_br, d_pe, d_ft}, 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        push_exp(N_RUN2 / 4);
        rst = 1'b0;
        t_ticks = 0;
        for (int cyc = 1; cyc <= N_RUN2; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc <= 8) check("restart_pix_en_phase", {31'd0, s_pe}, {31'd0, (cyc % 4) == 0});
            if (cyc == 4) check("restart_first_adv", {22'd0, s_h, s_v}, {22'd0, 10'd1, 10'd0});
            if (t_ft) begin
                t_ticks++;
                check("tiny_frame_tick_cycle", cyc, t_ticks * 16);
`ifdef FRAME_COUNT_EN
                check("tiny_frame_count", {24'd0, t_fc}, t_ticks % 256);
`endif
            end
        end
        check("tiny_frame_tick_count", t_ticks, N_RUN2 / 16);
        @(negedge clk);
        #1;
        check("sb_queue_drained", sb_q.size(), 0);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
